// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the N x N systolic matrix engine.
package systolic_pkg;

  // Controller states of the job sequencer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Accumulator width: full signed product plus 8 guard bits for K up to 255.
  function automatic int acc_w(input int data_w);
    return 2 * data_w + 8;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary grid.
// Forwards a (right) and b (down) with their valid tags one cycle per hop and
// accumulates a*b when both incoming tags are set.
// Optional build macro SYSTOLIC_ACC_SAT_EN: saturating, sticky-clamp accumulate.
module systolic_pe import systolic_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = acc_w(DEF_DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              va_in,
  input  logic              vb_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              va_out,
  output logic              vb_out,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic                       mac;

  assign prod     = $signed(a_in) * $signed(b_in);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign mac      = va_in & vb_in;

  // Operand and tag forwarding to the right/lower neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out  <= '0;
      b_out  <= '0;
      va_out <= 1'b0;
      vb_out <= 1'b0;
    end else begin
      a_out  <= a_in;
      b_out  <= b_in;
      va_out <= va_in;
      vb_out <= vb_in;
    end
  end

`ifdef SYSTOLIC_ACC_SAT_EN
  logic           sat;
  logic [ACC_W:0] sum;

  assign sum = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

  // Saturating accumulate; once clamped the PE holds until the next clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (mac && !sat) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        sat <= 1'b1;
        acc <= sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end
`else
  // Two's-complement wrapping accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (mac) begin
      acc <= acc + prod_ext;
    end
  end
`endif

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic matrix multiply C = A*B.
// A arrives by columns, B by rows; an internal skew front-end aligns the
// operands, a flush timer drains the grid, and rows are read out serially
// with out_valid/out_ready back-pressure.
// Optional build macro SYSTOLIC_ACC_SAT_EN (handled inside systolic_pe).
//
// state  | meaning
// IDLE   | waiting for start; start clears accumulators and latches k_len
// STREAM | accepting k_len operand beats (in_ready=1)
// FLUSH  | 2N-1 cycles for the last beat to reach and update PE(N-1,N-1)
// OUTPUT | presenting accumulator row r until handshake, done after row N-1
module systolic_array_nxn import systolic_pkg::*; #(
  parameter int N      = 3,
  parameter int DATA_W = DEF_DATA_W,
  parameter int K_MAX  = 255,
  parameter int KW     = 8,
  parameter int ACC_W  = acc_w(DATA_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATA_W-1:0]    a_vec,
  input  logic [N*DATA_W-1:0]    b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_W-1:0]     out_row,
  output logic [clog2(N)-1:0]    out_row_idx,
  output logic                   done
);

  localparam int IW = clog2(N);
  localparam int FW = clog2(2 * N);

  state_t          state;
  logic [KW-1:0]   beats_left;
  logic [FW-1:0]   flush_cnt;
  logic [IW-1:0]   row_idx;
  logic [KW-1:0]   k_eff;
  logic            accept;
  logic            acc_clr;

  logic [DATA_W-1:0] a_sk  [N];
  logic [DATA_W-1:0] b_sk  [N];
  logic              va_sk [N];
  logic              vb_sk [N];

  logic [DATA_W-1:0] a_h  [N][N];
  logic [DATA_W-1:0] b_v  [N][N];
  logic              va_h [N][N];
  logic              vb_v [N][N];
  logic [ACC_W-1:0]  acc  [N][N];

  assign accept      = in_valid & in_ready;
  assign acc_clr     = (state == IDLE) & start;
  assign k_eff       = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign out_row_idx = row_idx;

  // Skew front-end: lane i sees the beat i cycles later than lane 0;
  // cycles without an accepted beat inject zero data with a cleared tag.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] a_sr  [i+1];
    logic [DATA_W-1:0] b_sr  [i+1];
    logic              va_sr [i+1];
    logic              vb_sr [i+1];

    // Shift register per lane, depth i+1.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s]  <= '0;
          b_sr[s]  <= '0;
          va_sr[s] <= 1'b0;
          vb_sr[s] <= 1'b0;
        end
      end else begin
        a_sr[0]  <= accept ? a_vec[i*DATA_W +: DATA_W] : '0;
        b_sr[0]  <= accept ? b_vec[i*DATA_W +: DATA_W] : '0;
        va_sr[0] <= accept;
        vb_sr[0] <= accept;
        for (int s = 1; s <= i; s++) begin
          a_sr[s]  <= a_sr[s-1];
          b_sr[s]  <= b_sr[s-1];
          va_sr[s] <= va_sr[s-1];
          vb_sr[s] <= vb_sr[s-1];
        end
      end
    end

    assign a_sk[i]  = a_sr[i];
    assign b_sk[i]  = b_sr[i];
    assign va_sk[i] = va_sr[i];
    assign vb_sk[i] = vb_sr[i];
  end

  // PE grid: a/tag travels right along row i, b/tag travels down column j.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_w;
      logic [DATA_W-1:0] b_w;
      logic              va_w;
      logic              vb_w;

      if (j == 0) begin : g_a_edge
        assign a_w  = a_sk[i];
        assign va_w = va_sk[i];
      end else begin : g_a_int
        assign a_w  = a_h[i][j-1];
        assign va_w = va_h[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_w  = b_sk[j];
        assign vb_w = vb_sk[j];
      end else begin : g_b_int
        assign b_w  = b_v[i-1][j];
        assign vb_w = vb_v[i-1][j];
      end

      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .a_in   (a_w),
        .b_in   (b_w),
        .va_in  (va_w),
        .vb_in  (vb_w),
        .a_out  (a_h[i][j]),
        .b_out  (b_v[i][j]),
        .va_out (va_h[i][j]),
        .vb_out (vb_v[i][j]),
        .acc    (acc[i][j])
      );
    end
  end

  // Job sequencer with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beats_left <= '0;
      flush_cnt  <= '0;
      row_idx    <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            row_idx    <= '0;
            beats_left <= k_eff;
            if (k_eff == '0) begin
              state     <= OUTPUT;
              out_valid <= 1'b1;
            end else begin
              state    <= STREAM;
              in_ready <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (beats_left == KW'(1)) begin
              state     <= FLUSH;
              in_ready  <= 1'b0;
              flush_cnt <= FW'(2 * N - 2);
            end else begin
              beats_left <= beats_left - 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            row_idx   <= '0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (row_idx == IW'(N - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readout mux: row r of the accumulators while a row is presented, else zero.
  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int r = 0; r < N; r++) begin
        if (row_idx == IW'(r)) begin
          for (int j = 0; j < N; j++) begin
            out_row[j*ACC_W +: ACC_W] = acc[r][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Self-checking bench for systolic_array_nxn: random and directed jobs checked
// against a plain matrix-product reference model.
module tb_systolic_array_nxn;

  localparam int N      = 3;
  localparam int DATA_W = 8;
  localparam int KW     = 8;
  localparam int K_MAX  = 255;
  localparam int ACC_W  = 2 * DATA_W + 8;
  localparam int IW     = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*DATA_W-1:0]  a_vec;
  logic [N*DATA_W-1:0]  b_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*ACC_W-1:0]   out_row;
  logic [IW-1:0]        out_row_idx;
  logic                 done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int               A     [0:N-1][0:K_MAX];
  int               B     [0:K_MAX][0:N-1];
  logic [ACC_W-1:0] exp_c [0:N-1][0:N-1];

  systolic_array_nxn #(
    .N      (N),
    .DATA_W (DATA_W),
    .K_MAX  (K_MAX),
    .KW     (KW),
    .ACC_W  (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // C = A*B over k terms, accumulated in the engine's arithmetic.
  function automatic void build_model(input int k);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s;
        bit     sat;
        s   = 0;
        sat = 0;
        for (int kk = 0; kk < k; kk++) begin
          longint p;
          p = longint'(A[i][kk]) * longint'(B[kk][j]);
`ifdef SYSTOLIC_ACC_SAT_EN
          if (!sat) begin
            s = s + p;
            if (s > (longint'(1) <<< (ACC_W - 1)) - 1) begin
              s   = (longint'(1) <<< (ACC_W - 1)) - 1;
              sat = 1;
            end else if (s < -(longint'(1) <<< (ACC_W - 1))) begin
              s   = -(longint'(1) <<< (ACC_W - 1));
              sat = 1;
            end
          end
`else
          s = s + p;
`endif
        end
        exp_c[i][j] = s[ACC_W-1:0];
      end
    end
  endfunction

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        A[i][kk] = int'($urandom_range(0, 255)) - 128;
        B[kk][i] = int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  // Runs one job: gap_mode 0 continuous, 1 pattern 1,0,0,..., 2 random valid.
  task automatic do_job(input int k, input int gap_mode, input int stall_row,
                        input int stall_len, input bit poke_start);
    int                 idx;
    int                 budget;
    int                 r;
    int                 start_cyc;
    int                 lat;
    bit                 acc_now;
    logic [N*ACC_W-1:0] held;
    logic [N*ACC_W-1:0] exp_row;

    build_model(k);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    start     = 1'b1;
    k_len     = KW'(k);
    start_cyc = cyc;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got=%b exp=1", busy);
    end
    checks++;
    if (k > 0 && in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_stream got=%b exp=1", in_ready);
    end else if (k == 0 && (in_ready !== 1'b0 || out_valid !== 1'b1)) begin
      errors++;
      $display("FAIL klen0_entry in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid);
    end

    idx    = 0;
    budget = 0;
    while (idx < k && budget < 4000) begin
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((budget % 3) == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          a_vec[i*DATA_W +: DATA_W] = DATA_W'(A[i][idx]);
          b_vec[i*DATA_W +: DATA_W] = DATA_W'(B[idx][i]);
        end
      end else begin
        a_vec = (N*DATA_W)'($urandom);
        b_vec = (N*DATA_W)'($urandom);
      end
      if (poke_start && idx == 1) begin
        start = 1'b1;
        k_len = KW'(1);
      end else begin
        start = 1'b0;
      end
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) idx++;
      budget++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (idx != k) begin
      errors++;
      $display("FAIL stream_beats got=%0d exp=%0d", idx, k);
    end

    // Junk on the operand port while draining must be ignored.
    budget = 0;
    while (!out_valid && budget < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      a_vec    = (N*DATA_W)'($urandom);
      b_vec    = (N*DATA_W)'($urandom);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_flush got=%b exp=0", in_ready);
      end
      tick();
      budget++;
    end
    in_valid = 1'b0;

    r      = 0;
    budget = 0;
    while (r < N && budget < 400) begin
      if (out_valid) begin
        for (int j = 0; j < N; j++) exp_row[j*ACC_W +: ACC_W] = exp_c[r][j];
        checks++;
        if (out_row_idx !== IW'(r)) begin
          errors++;
          $display("FAIL row_idx got=%0d exp=%0d", out_row_idx, r);
        end
        checks++;
        if (out_row !== exp_row) begin
          errors++;
          $display("FAIL row_data r=%0d got=%h exp=%h", r, out_row, exp_row);
        end
        if (r == stall_row && stall_len > 0) begin
          held      = out_row;
          out_ready = 1'b0;
          repeat (stall_len) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_row_idx !== IW'(r) || out_row !== held) begin
              errors++;
              $display("FAIL stall_hold valid=%b idx=%0d row=%h exp 1/%0d/%h",
                       out_valid, out_row_idx, out_row, r, held);
            end
          end
          out_ready = 1'b1;
        end
        tick();
        r++;
      end else begin
        tick();
      end
      budget++;
    end
    checks++;
    if (r != N) begin
      errors++;
      $display("FAIL rows_delivered got=%0d exp=%0d", r, N);
    end

    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b out_valid=%b exp 1/0/0", done, busy, out_valid);
    end
    lat = cyc - start_cyc;
    if (gap_mode == 0 && stall_len == 0) begin
      checks++;
      if (lat != ((k == 0) ? N + 1 : k + 3 * N)) begin
        errors++;
        $display("FAIL latency got=%0d exp=%0d", lat, (k == 0) ? N + 1 : k + 3 * N);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single got=%b exp=0", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b in_ready=%b out_valid=%b done=%b exp 0", busy, in_ready, out_valid, done);
    end
    checks++;
    if (out_row !== '0 || out_row_idx !== '0) begin
      errors++;
      $display("FAIL reset_row row=%h idx=%0d exp 0", out_row, out_row_idx);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    for (int kk = 0; kk < N; kk++) begin
      for (int i = 0; i < N; i++) begin
        A[i][kk] = (i == kk) ? 1 : 0;
        B[kk][i] = kk * N + i + 1;
      end
    end
    do_job(N, 0, -1, 0, 1'b0);
  endtask

  task automatic test_bubbles();
    fill_random(4);
    do_job(4, 1, -1, 0, 1'b0);
    fill_random(7);
    do_job(7, 2, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_random(3);
    do_job(3, 0, 1, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_random(5);
    do_job(5, 0, -1, 0, 1'b0);
    fill_random(2);
    do_job(2, 0, -1, 0, 1'b0);
  endtask

  task automatic test_extremes();
    // 255 products of (-128)*(-128) each; the model applies ACC_W arithmetic.
    for (int kk = 0; kk < K_MAX; kk++) begin
      for (int i = 0; i < N; i++) begin
        A[i][kk] = -128;
        B[kk][i] = -128;
      end
    end
    do_job(K_MAX, 0, -1, 0, 1'b0);
  endtask

  task automatic test_control();
    fill_random(6);
    do_job(6, 0, -1, 0, 1'b1);

    fill_random(5);
    start = 1'b1;
    k_len = KW'(5);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_state busy=%b in_ready=%b out_valid=%b exp 1/0/0", busy, in_ready, out_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midjob busy=%b out_valid=%b in_ready=%b done=%b exp 0", busy, out_valid, in_ready, done);
    end
    rst_n = 1'b1;
    tick();
    fill_random(4);
    do_job(4, 2, -1, 0, 1'b0);
  endtask

  task automatic test_klen_zero();
    do_job(0, 0, -1, 0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_vec     = '0;
    b_vec     = '0;
    test_reset();
    test_identity();
    test_bubbles();
    test_backpressure();
    test_back_to_back();
    test_extremes();
    test_control();
    test_klen_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
